// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_decoder
//  Purpose  : Reconstructs the four digits of a multiplexed, active-low
//             seven-segment drive (ping-pong counter display). A digit is
//             accepted only after {an,seg} has held stable for SETTLE
//             samples. Four accepted positions form a frame that is
//             published with a one-cycle valid pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, an/seg synchronous to it
//    rst_n       in   asynchronous reset, active-HIGH despite the name
//    an[3:0]     in   anode selects, active-low, one-hot-low
//    seg[6:0]    in   segments, active-low, seg[6]=a .. seg[0]=g
//    digit3..0   out  published codes: 0-9, 10=UP, 11=DOWN, 15=illegal
//    value[4:0]  out  digit3*10 + digit2
//    dir         out  1=UP, 0=DOWN (from digit0)
//    frame_valid out  one-cycle pulse per published frame
//    pat_err     out  sticky pattern error
//    dir_err     out  arrow digits disagree or are not arrows
//    stale       out  no frame for TIMEOUT cycles
//    chg_cnt     out  count of publishes that changed {value,dir}
//  Optional : SEG_SCAN_CHG_CNT_EN builds the chg_cnt counter; otherwise 0.
// ============================================================================
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [4:0] value,
  output logic       dir,
  output logic       frame_valid,
  output logic       pat_err,
  output logic       dir_err,
  output logic       stale,
  output logic [7:0] chg_cnt
);

  localparam int                 c_sw      = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [c_sw-1:0]    c_settle  = c_sw'(SETTLE);
  localparam logic [15:0]        c_timeout = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_WAIT    = 1'b0,
    ST_SETTLED = 1'b1
  } state_t;

  function automatic logic [3:0] f_decode(input logic [6:0] s);
    case (s)
      7'b0000001: f_decode = 4'd0;
      7'b1001111: f_decode = 4'd1;
      7'b0010010: f_decode = 4'd2;
      7'b0000110: f_decode = 4'd3;
      7'b1001100: f_decode = 4'd4;
      7'b0100100: f_decode = 4'd5;
      7'b0100000: f_decode = 4'd6;
      7'b0001111: f_decode = 4'd7;
      7'b0000000: f_decode = 4'd8;
      7'b0000100: f_decode = 4'd9;
      7'b0011101: f_decode = 4'd10;  // UP arrow
      7'b1100011: f_decode = 4'd11;  // DOWN arrow
      default:    f_decode = 4'd15;
    endcase
  endfunction

  state_t          r_state, w_next;
  logic [10:0]     r_samp;
  logic            r_diff;          // r_samp differs from the sample before it
  logic [c_sw-1:0] r_stab;
  logic [3:0]      r_seen, w_seen_nxt;
  logic [3:0]      r_pend [0:3];
  logic [3:0]      r_dig3, r_dig2, r_dig1, r_dig0;
  logic [4:0]      r_value, w_value;
  logic            r_dir, w_dir;
  logic            r_fv, r_pat;
  logic [15:0]     r_tmo;
  logic            w_capture, w_slot_ok, w_publish, w_val_bad, w_pat_set;
  logic [1:0]      w_slot;
  logic [3:0]      w_code;
  logic [10:0]     w_in;

  assign w_in   = {an, seg};
  assign w_code = f_decode(r_samp[6:0]);

  always_comb begin
    w_slot_ok = 1'b1;
    w_slot    = 2'd0;
    case (r_samp[10:7])
      4'b0111: w_slot = 2'd3;
      4'b1011: w_slot = 2'd2;
      4'b1101: w_slot = 2'd1;
      4'b1110: w_slot = 2'd0;
      default: w_slot_ok = 1'b0;
    endcase
  end

  // The capture is taken on the WAIT->SETTLED transition so that it occurs
  // exactly once per stable period. With SETTLE=1 every new sample is
  // already settled, so a change seen in SETTLED captures again in place.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (r_stab == c_settle) begin
          w_next    = ST_SETTLED;
          w_capture = 1'b1;
        end
      end
      ST_SETTLED: begin
        if (r_diff) begin
          if (r_stab == c_settle) w_capture = 1'b1;
          else                    w_next    = ST_WAIT;
        end
      end
      default: w_next = ST_WAIT;
    endcase
  end

  assign w_publish = (r_seen == 4'b1111);
  assign w_val_bad = (r_pend[3] > 4'd1) || (r_pend[2] > 4'd9);
  assign w_value   = w_val_bad ? 5'd0 : (5'(r_pend[3]) * 5'd10 + 5'(r_pend[2]));
  assign w_dir     = (r_pend[0] == 4'd10) ? 1'b1 :
                     (r_pend[0] == 4'd11) ? 1'b0 : r_dir;
  assign w_pat_set = (w_capture && (!w_slot_ok || w_code == 4'd15)) ||
                     (w_publish && w_val_bad);

  always_comb begin
    w_seen_nxt = w_publish ? 4'b0000 : r_seen;
    if (w_capture && w_slot_ok) w_seen_nxt[w_slot] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= ST_WAIT;
      r_samp  <= '0;
      r_diff  <= 1'b0;
      r_stab  <= '0;
      r_seen  <= 4'b0000;
      for (int i = 0; i < 4; i++) r_pend[i] <= 4'd15;
      r_dig3  <= 4'd15;
      r_dig2  <= 4'd15;
      r_dig1  <= 4'd15;
      r_dig0  <= 4'd15;
      r_value <= 5'd0;
      r_dir   <= 1'b1;
      r_fv    <= 1'b0;
      r_pat   <= 1'b0;
      r_tmo   <= 16'd0;
    end else begin
      r_state <= w_next;
      r_samp  <= w_in;
      r_diff  <= (w_in != r_samp);
      if (w_in != r_samp)         r_stab <= {{(c_sw-1){1'b0}}, 1'b1};
      else if (r_stab != c_settle) r_stab <= r_stab + 1'b1;
      r_seen  <= w_seen_nxt;
      if (w_capture && w_slot_ok) r_pend[w_slot] <= w_code;
      if (w_pat_set) r_pat <= 1'b1;
      r_fv <= w_publish;
      if (w_publish) begin
        r_dig3  <= r_pend[3];
        r_dig2  <= r_pend[2];
        r_dig1  <= r_pend[1];
        r_dig0  <= r_pend[0];
        r_value <= w_value;
        r_dir   <= w_dir;
        r_tmo   <= 16'd0;
      end else if (r_tmo != c_timeout) begin
        r_tmo   <= r_tmo + 16'd1;
      end
    end
  end

`ifdef SEG_SCAN_CHG_CNT_EN
  logic [7:0] r_chg_cnt;
  // The published {value,dir} registers hold the previous frame, and reset
  // to {0,1}, so they serve directly as the comparison reference.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      r_chg_cnt <= 8'd0;
    else if (w_publish && ({w_value, w_dir} != {r_value, r_dir}))
      r_chg_cnt <= r_chg_cnt + 8'd1;
  end
  assign chg_cnt = r_chg_cnt;
`else
  assign chg_cnt = 8'd0;
`endif

  assign digit3      = r_dig3;
  assign digit2      = r_dig2;
  assign digit1      = r_dig1;
  assign digit0      = r_dig0;
  assign value       = r_value;
  assign dir         = r_dir;
  assign frame_valid = r_fv;
  assign pat_err     = r_pat;
  assign stale       = (r_tmo == c_timeout);
  assign dir_err     = (r_dig1 != r_dig0) || ((r_dig0 != 4'd10) && (r_dig0 != 4'd11));

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_decoder
//  Purpose  : Directed self-checking bench for seg_scan_decoder. Inputs are
//             driven and outputs sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] UP = 7'b0011101, DN = 7'b1100011, BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an = 4'b0111;
  logic [6:0] seg = 7'b0000001;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [4:0] value;
  logic       dir, frame_valid, pat_err, dir_err, stale;
  logic [7:0] chg_cnt;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  logic [7:0] exp_chg;

  seg_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .value(value), .dir(dir), .frame_valid(frame_valid), .pat_err(pat_err),
    .dir_err(dir_err), .stale(stale), .chg_cnt(chg_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0, input int n);
    hold(4'b0111, s3, n);
    hold(4'b1011, s2, n);
    hold(4'b1101, s1, n);
    hold(4'b1110, s0, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_digit3", digit3, 15);
    check("rst_digit2", digit2, 15);
    check("rst_digit1", digit1, 15);
    check("rst_digit0", digit0, 15);
    check("rst_value", value, 0);
    check("rst_dir", dir, 1);
    check("rst_fv", frame_valid, 0);
    check("rst_pat_err", pat_err, 0);
    check("rst_stale", stale, 0);
    check("rst_chg_cnt", chg_cnt, 0);
    check("rst_dir_err", dir_err, 1);

    // Frame 03 UP
    scan4(S0, S3, UP, UP, 8);
    check("a_fv_cnt", fv_cnt, 1);
    check("a_fv_low", frame_valid, 0);
    check("a_digit3", digit3, 0);
    check("a_digit2", digit2, 3);
    check("a_digit1", digit1, 10);
    check("a_digit0", digit0, 10);
    check("a_value", value, 3);
    check("a_dir", dir, 1);
    check("a_pat_err", pat_err, 0);
    check("a_dir_err", dir_err, 0);
    check("a_stale", stale, 0);

    // Frame 15 DOWN
    scan4(S1, S5, DN, DN, 8);
    check("b_fv_cnt", fv_cnt, 2);
    check("b_digit3", digit3, 1);
    check("b_digit2", digit2, 5);
    check("b_value", value, 15);
    check("b_dir", dir, 0);
    check("b_dir_err", dir_err, 0);

    // Disagreeing arrows
    scan4(S1, S5, UP, DN, 8);
    check("c_fv_cnt", fv_cnt, 3);
    check("c_dir_err", dir_err, 1);
    check("c_pat_err", pat_err, 0);
    check("c_dir", dir, 0);

    // Unsettled scanning: no capture, stale after timeout
    for (int k = 0; k < 5500; k++) scan4(S0, S3, UP, UP, 3);
    check("d_fv_cnt", fv_cnt, 3);
    check("d_stale", stale, 1);
    check("d_value_kept", value, 15);
    scan4(S0, S3, UP, UP, 8);
    check("d2_fv_cnt", fv_cnt, 4);
    check("d2_stale", stale, 0);
    check("d2_value", value, 3);
    check("d2_dir", dir, 1);

    // Reset mid-frame discards pending slots and mask
    hold(4'b0111, S1, 8);
    hold(4'b1011, S4, 8);
    do_reset();
    check("e_digit3", digit3, 15);
    check("e_value", value, 0);
    hold(4'b1011, S4, 8);
    hold(4'b1101, UP, 8);
    hold(4'b1110, UP, 8);
    check("e_fv_cnt", fv_cnt, 4);
    check("e_digit2", digit2, 15);

    // Change counter: values 3,3,4,5 with dir UP
    do_reset();
    scan4(S0, S3, UP, UP, 8);
    scan4(S0, S3, UP, UP, 8);
    scan4(S0, S4, UP, UP, 8);
    scan4(S0, S5, UP, UP, 8);
`ifdef SEG_SCAN_CHG_CNT_EN
    exp_chg = 8'd3;
`else
    exp_chg = 8'd0;
`endif
    check("f_fv_cnt", fv_cnt, 8);
    check("f_value", value, 5);
    check("f_chg_cnt", chg_cnt, exp_chg);

    // Non one-hot anode pattern
    hold(4'b0011, S0, 8);
    check("g_pat_err", pat_err, 1);
    check("g_fv_cnt", fv_cnt, 8);
    check("g_digit2_kept", digit2, 5);
    // Blank segments on a valid position
    scan4(S0, BL, UP, UP, 8);
    check("g_fv_cnt2", fv_cnt, 9);
    check("g_digit2_ill", digit2, 15);
    check("g_value_bad", value, 0);
    check("g_pat_sticky", pat_err, 1);

    // Tens digit out of range
    do_reset();
    check("h_pat_clr", pat_err, 0);
    scan4(S2, S0, UP, UP, 8);
    check("h_fv_cnt", fv_cnt, 10);
    check("h_digit3", digit3, 2);
    check("h_value", value, 0);
    check("h_pat_err", pat_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
